// File: rtl/rv32i_core.sv
// Single-cycle RV32I core with internal instruction memory, data memory and register file.
// Every instruction fetches, executes and writes back in one clock; reset only redirects the PC.

module rv32i_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regFile [0:31];

  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) regFile[waddr] <= wdata;
  end

  // x0 is never stored; whatever sits in regFile[0] is masked on read
  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regFile[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regFile[raddr2];
endmodule

module rv32i_imem #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  logic [31:0] mem [0:WORDS-1];

  // Load port for program images; the core itself never writes instructions
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign data = mem[addr];
endmodule

module rv32i_dmem #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    byte_en,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:WORDS-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];
endmodule

module rv32i_core #(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic reset
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  logic [31:0] pc = RESET_PC;
  logic [31:0] pc_in, pc_plus4, fetched, instruction_mux_out;
  logic [31:0] mux_a_out, mux_b_out, alu_out, imm;
  logic [31:0] rs1_data, rs2_data, load_word, load_shift, load_data, store_data, wb_data;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [15:0] load_half;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [3:0]  byte_en;
  logic        sel_a_pc, sel_b_imm, rd_we, mem_we, is_load, wb_link;
  logic        is_jal, is_jalr, is_branch, take_branch;
  alu_op_t     alu_op;

  function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pc_in;
  end

  rv32i_imem #(.WORDS(IMEM_WORDS)) insn_memory (
    .clk(clk), .we(1'b0), .waddr('0), .wdata('0),
    .addr(pc[IAW+1:2]), .data(fetched)
  );

  // A NOP during reset guarantees no architectural writes while held
  assign instruction_mux_out = reset ? fetched : 32'h0000_0013;
  assign opcode = instruction_mux_out[6:0];
  assign funct3 = instruction_mux_out[14:12];

  assign imm_i = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:20]};
  assign imm_s = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:25], instruction_mux_out[11:7]};
  assign imm_b = {{19{instruction_mux_out[31]}}, instruction_mux_out[31], instruction_mux_out[7],
                  instruction_mux_out[30:25], instruction_mux_out[11:8], 1'b0};
  assign imm_u = {instruction_mux_out[31:12], 12'd0};
  assign imm_j = {{11{instruction_mux_out[31]}}, instruction_mux_out[31], instruction_mux_out[19:12],
                  instruction_mux_out[20], instruction_mux_out[30:21], 1'b0};

  rv32i_regfile register_file (
    .clk(clk), .we(rd_we), .waddr(instruction_mux_out[11:7]), .wdata(wb_data),
    .raddr1(instruction_mux_out[19:15]), .raddr2(instruction_mux_out[24:20]),
    .rdata1(rs1_data), .rdata2(rs2_data)
  );

  always_comb begin
    sel_a_pc  = 1'b0;
    sel_b_imm = 1'b1;
    imm       = imm_i;
    alu_op    = ALU_ADD;
    rd_we     = 1'b0;
    mem_we    = 1'b0;
    is_load   = 1'b0;
    wb_link   = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_branch = 1'b0;
    case (opcode)
      7'b0110111: begin imm = imm_u; alu_op = ALU_PASSB; rd_we = 1'b1; end
      7'b0010111: begin sel_a_pc = 1'b1; imm = imm_u; rd_we = 1'b1; end
      7'b1101111: begin sel_a_pc = 1'b1; imm = imm_j; rd_we = 1'b1; wb_link = 1'b1; is_jal = 1'b1; end
      7'b1100111: begin rd_we = 1'b1; wb_link = 1'b1; is_jalr = 1'b1; end
      7'b1100011: begin sel_a_pc = 1'b1; imm = imm_b; is_branch = 1'b1; end
      7'b0000011: begin
        is_load = 1'b1;
        rd_we   = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      7'b0100011: begin imm = imm_s; mem_we = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010); end
      // funct7[5] only means SRAI for immediates; ADDI must never turn into SUB
      7'b0010011: begin rd_we = 1'b1; alu_op = alu_sel(funct3, (funct3 == 3'b101) && instruction_mux_out[30]); end
      7'b0110011: begin sel_b_imm = 1'b0; rd_we = 1'b1; alu_op = alu_sel(funct3, instruction_mux_out[30]); end
      default: ;
    endcase
  end

  assign mux_a_out = sel_a_pc  ? pc  : rs1_data;
  assign mux_b_out = sel_b_imm ? imm : rs2_data;

  always_comb begin
    alu_out = 32'd0;
    case (alu_op)
      ALU_ADD:   alu_out = mux_a_out + mux_b_out;
      ALU_SUB:   alu_out = mux_a_out - mux_b_out;
      ALU_SLL:   alu_out = mux_a_out << mux_b_out[4:0];
      ALU_SLT:   alu_out = {31'd0, $signed(mux_a_out) < $signed(mux_b_out)};
      ALU_SLTU:  alu_out = {31'd0, mux_a_out < mux_b_out};
      ALU_XOR:   alu_out = mux_a_out ^ mux_b_out;
      ALU_SRL:   alu_out = mux_a_out >> mux_b_out[4:0];
      ALU_SRA:   alu_out = $signed(mux_a_out) >>> mux_b_out[4:0];
      ALU_OR:    alu_out = mux_a_out | mux_b_out;
      ALU_AND:   alu_out = mux_a_out & mux_b_out;
      ALU_PASSB: alu_out = mux_b_out;
      default:   alu_out = 32'd0;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  take_branch = (rs1_data == rs2_data);
      3'b001:  take_branch = (rs1_data != rs2_data);
      3'b100:  take_branch = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  take_branch = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  take_branch = (rs1_data <  rs2_data);
      3'b111:  take_branch = (rs1_data >= rs2_data);
      default: take_branch = 1'b0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    pc_in = pc_plus4;
    if (is_jal || (is_branch && take_branch)) pc_in = alu_out;
    else if (is_jalr)                         pc_in = {alu_out[31:1], 1'b0};
  end

  always_comb begin
    byte_en    = 4'b0000;
    store_data = rs2_data;
    if (mem_we) begin
      case (funct3)
        3'b000:  begin byte_en = 4'b0001 << alu_out[1:0]; store_data = {4{rs2_data[7:0]}}; end
        3'b001:  begin byte_en = alu_out[1] ? 4'b1100 : 4'b0011; store_data = {2{rs2_data[15:0]}}; end
        default: byte_en = 4'b1111;
      endcase
    end
  end

  rv32i_dmem #(.WORDS(DMEM_WORDS)) data_memory (
    .clk(clk), .byte_en(byte_en), .addr(alu_out[DAW+1:2]),
    .wdata(store_data), .rdata(load_word)
  );

  // Sub-word loads pick lanes inside the aligned word; misalignment never traps
  assign load_shift = load_word >> {alu_out[1:0], 3'b000};
  assign load_half  = alu_out[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    case (funct3)
      3'b000:  load_data = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'd0, load_shift[7:0]};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = load_word;
    endcase
  end

  assign wb_data = is_load ? load_data : (wb_link ? pc_plus4 : alu_out);
endmodule

// File: tb/tb_rv32i_core.sv
// Self-checking bench for rv32i_core: directed vector table, hand sequences for
// reset/memory/jump corners, and a random program checked against a reference model.

module tb_rv32i_core;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rv32i_core dut (.clk(clk), .reset(reset));

  typedef struct {
    logic [63:0] name;
    logic [31:0] insn;
    logic [31:0] x1v;
    logic [31:0] x2v;
    logic [31:0] exp_x3;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic [19:0] uimm;
  } op_t;

  vec_t        vecs[$];
  op_t         ops[$];
  logic [31:0] mreg [0:31];
  logic [7:0]  mb   [0:1023];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset, then clear both memories and seed regFile[k]=k
  task automatic prep();
    reset = 1'b0;
    step();
    step();
    for (int k = 0; k < 32; k++) dut.register_file.regFile[k] = 32'(k);
    for (int k = 0; k < 1024; k++) begin
      dut.insn_memory.mem[k] = 32'd0;
      dut.data_memory.mem[k] = 32'd0;
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic add_vec(input logic [63:0] name, input logic [31:0] insn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] x3, input logic [31:0] npc);
    vec_t v;
    v.name = name; v.insn = insn; v.x1v = a; v.x2v = b; v.exp_x3 = x3; v.exp_pc = npc;
    vecs.push_back(v);
  endtask

  // Random-program encoding tables: R ops 0-9, I ops 10-18
  function automatic logic [31:0] encode_op(input op_t o);
    logic [2:0] r_f3 [0:9]  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    logic [2:0] i_f3 [0:8]  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5, 3'd5};
    logic [2:0] m_f3 [0:6]  = '{3'd2, 3'd2, 3'd0, 3'd4, 3'd0, 3'd1, 3'd1};
    if (o.kind <= 9)
      return enc_r((o.kind == 1 || o.kind == 7) ? 7'h20 : 7'h00, o.rs2, o.rs1, r_f3[o.kind], o.rd);
    if (o.kind <= 18) return enc_i(o.imm, o.rs1, i_f3[o.kind-10], o.rd, 7'h13);
    if (o.kind == 19) return enc_u(o.uimm, o.rd, 7'h37);
    if (o.kind == 20 || o.kind == 22 || o.kind == 25) return enc_s(o.imm, o.rs2, 5'd0, m_f3[o.kind-20]);
    return enc_i(o.imm, 5'd0, m_f3[o.kind-20], o.rd, 7'h03);
  endfunction

  initial begin
    // ---------------- directed single-instruction vectors ----------------
    add_vec("addi",  enc_i(12'd52, 5'd1, 3'd0, 5'd3, 7'h13), 32'd1, 32'd0, 32'd53, 32'd4);
    add_vec("addiovf", enc_i(12'd1, 5'd1, 3'd0, 5'd3, 7'h13), 32'h7FFF_FFFF, 32'd0, 32'h8000_0000, 32'd4);
    add_vec("sub",   enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 32'hFFFF_FFFE, 32'd4);
    add_vec("srai",  enc_i(12'h404, 5'd1, 3'd5, 5'd3, 7'h13), 32'h8000_0000, 32'd0, 32'hF800_0000, 32'd4);
    add_vec("srli",  enc_i(12'h004, 5'd1, 3'd5, 5'd3, 7'h13), 32'h8000_0000, 32'd0, 32'h0800_0000, 32'd4);
    add_vec("slt",   enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3), 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd4);
    add_vec("sltu",  enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd3), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd4);
    add_vec("sltiu", enc_i(12'hFFF, 5'd1, 3'd3, 5'd3, 7'h13), 32'd5, 32'd0, 32'd1, 32'd4);
    add_vec("xori",  enc_i(12'hFFF, 5'd1, 3'd4, 5'd3, 7'h13), 32'h0000_0F0F, 32'd0, 32'hFFFF_F0F0, 32'd4);
    add_vec("sll",   enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd3), 32'd1, 32'h23, 32'd8, 32'd4);
    add_vec("sra",   enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3), 32'hFFFF_FFF0, 32'd2, 32'hFFFF_FFFC, 32'd4);
    add_vec("or",    enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd3), 32'hF0, 32'h0F, 32'hFF, 32'd4);
    add_vec("and",   enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd3), 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 32'd4);
    add_vec("lui",   enc_u(20'h12345, 5'd3, 7'h37), 32'd0, 32'd0, 32'h1234_5000, 32'd4);
    add_vec("auipc", enc_u(20'h00001, 5'd3, 7'h17), 32'd0, 32'd0, 32'h0000_1000, 32'd4);
    add_vec("beq",   enc_b(13'd8, 5'd2, 5'd1, 3'd0), 32'd7, 32'd7, 32'd3, 32'd8);
    add_vec("beqneg", enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'd7, 32'd7, 32'd3, 32'hFFFF_FFF8);
    add_vec("bne",   enc_b(13'd8, 5'd2, 5'd1, 3'd1), 32'd7, 32'd7, 32'd3, 32'd4);
    add_vec("blt",   enc_b(13'd8, 5'd2, 5'd1, 3'd4), 32'hFFFF_FFFF, 32'd1, 32'd3, 32'd8);
    add_vec("bltu",  enc_b(13'd8, 5'd2, 5'd1, 3'd6), 32'hFFFF_FFFF, 32'd1, 32'd3, 32'd4);
    add_vec("bge",   enc_b(13'd8, 5'd2, 5'd1, 3'd5), 32'd1, 32'hFFFF_FFFF, 32'd3, 32'd8);
    add_vec("bgeu",  enc_b(13'd8, 5'd2, 5'd1, 3'd7), 32'd1, 32'hFFFF_FFFF, 32'd3, 32'd4);
    add_vec("jalr",  enc_i(12'd3, 5'd1, 3'd0, 5'd3, 7'h67), 32'd7, 32'd0, 32'd4, 32'd10);
    add_vec("jal",   enc_j(21'd16, 5'd3), 32'd0, 32'd0, 32'd4, 32'd16);
    add_vec("zero",  32'h0000_0000, 32'd0, 32'd0, 32'd3, 32'd4);
    add_vec("fence", 32'h0000_000F, 32'd0, 32'd0, 32'd3, 32'd4);
    add_vec("ecall", 32'h0000_0073, 32'd0, 32'd0, 32'd3, 32'd4);

    prep();
    check("reset_pc", dut.pc, 32'd0);
    check("reset_nop", dut.instruction_mux_out, 32'h0000_0013);

    foreach (vecs[i]) begin
      prep();
      dut.register_file.regFile[1] = vecs[i].x1v;
      dut.register_file.regFile[2] = vecs[i].x2v;
      dut.insn_memory.mem[0] = vecs[i].insn;
      reset = 1'b1;
      step();
      $display("vec %0d %s insn=%08h x3=%08h pc=%08h", i, vecs[i].name, vecs[i].insn,
               dut.register_file.regFile[3], dut.pc);
      check({vecs[i].name, "_x3"}, dut.register_file.regFile[3], vecs[i].exp_x3);
      check({vecs[i].name, "_pc"}, dut.pc, vecs[i].exp_pc);
    end

    // ---------------- basic program, then mid-program reset ----------------
    prep();
    dut.insn_memory.mem[0] = enc_i(12'd52, 5'd1, 3'd0, 5'd1, 7'h13);
    dut.insn_memory.mem[1] = enc_i(12'd4, 5'd1, 3'd5, 5'd2, 7'h13);
    reset = 1'b1;
    step(); check("prog_x1", dut.register_file.regFile[1], 32'd53); check("prog_pc1", dut.pc, 32'd4);
    step(); check("prog_x2", dut.register_file.regFile[2], 32'd3);  check("prog_pc2", dut.pc, 32'd8);
    step(); step();
    check("prog_pc4", dut.pc, 32'd16);
    check("prog_x3", dut.register_file.regFile[3], 32'd3);
    $display("seq program pc=%08h", dut.pc);
    reset = 1'b0;
    step(); check("rst_nop", dut.instruction_mux_out, 32'h0000_0013);
    step(); check("rst_pc", dut.pc, 32'd0);
    check("rst_x1", dut.register_file.regFile[1], 32'd53);
    check("rst_x2", dut.register_file.regFile[2], 32'd3);
    reset = 1'b1;
    step(); check("restart_x1", dut.register_file.regFile[1], 32'd105); check("restart_pc", dut.pc, 32'd4);
    step(); check("restart_x2", dut.register_file.regFile[2], 32'd6);
    $display("seq reset restart pc=%08h", dut.pc);

    // ---------------- x0 hardwiring ----------------
    prep();
    dut.register_file.regFile[0] = 32'hDEAD_BEEF;
    dut.register_file.regFile[1] = 32'd5;
    dut.register_file.regFile[2] = 32'd7;
    dut.insn_memory.mem[0] = enc_i(12'd5, 5'd1, 3'd0, 5'd0, 7'h13);
    dut.insn_memory.mem[1] = enc_r(7'h00, 5'd1, 5'd0, 3'd0, 5'd4);
    dut.insn_memory.mem[2] = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);
    reset = 1'b1;
    step(); step(); step();
    check("x0_read", dut.register_file.regFile[4], 32'd5);
    check("x0_sub", dut.register_file.regFile[3], 32'hFFFF_FFFE);
    $display("seq x0 x4=%08h", dut.register_file.regFile[4]);

    // ---------------- loads and stores ----------------
    prep();
    dut.register_file.regFile[5]  = 32'h1234_5678;
    dut.register_file.regFile[9]  = 32'h0000_0080;
    dut.register_file.regFile[14] = 32'h0000_1008;
    dut.insn_memory.mem[0] = enc_s(12'd8, 5'd5, 5'd0, 3'd2);
    dut.insn_memory.mem[1] = enc_s(12'd13, 5'd5, 5'd0, 3'd0);
    dut.insn_memory.mem[2] = enc_i(12'd8, 5'd0, 3'd0, 5'd6, 7'h03);
    dut.insn_memory.mem[3] = enc_i(12'd10, 5'd0, 3'd5, 5'd7, 7'h03);
    dut.insn_memory.mem[4] = enc_s(12'd14, 5'd9, 5'd0, 3'd0);
    dut.insn_memory.mem[5] = enc_i(12'd14, 5'd0, 3'd0, 5'd10, 7'h03);
    dut.insn_memory.mem[6] = enc_i(12'd14, 5'd0, 3'd4, 5'd11, 7'h03);
    dut.insn_memory.mem[7] = enc_i(12'd13, 5'd0, 3'd1, 5'd12, 7'h03);
    dut.insn_memory.mem[8] = enc_i(12'd0, 5'd14, 3'd2, 5'd13, 7'h03);
    reset = 1'b1;
    step(); step();
    check("sw_word", dut.data_memory.mem[2], 32'h1234_5678);
    check("sb_lane", dut.data_memory.mem[3], 32'h0000_7800);
    for (int k = 0; k < 7; k++) step();
    check("sb_lane2", dut.data_memory.mem[3], 32'h0080_7800);
    check("lb", dut.register_file.regFile[6], 32'h0000_0078);
    check("lhu", dut.register_file.regFile[7], 32'h0000_1234);
    check("lb_neg", dut.register_file.regFile[10], 32'hFFFF_FF80);
    check("lbu", dut.register_file.regFile[11], 32'h0000_0080);
    check("lh_misal", dut.register_file.regFile[12], 32'h0000_7800);
    check("lw_wrap", dut.register_file.regFile[13], 32'h1234_5678);
    $display("seq mem mem2=%08h mem3=%08h", dut.data_memory.mem[2], dut.data_memory.mem[3]);

    // ---------------- JAL / JALR chain ----------------
    prep();
    dut.insn_memory.mem[1] = enc_j(21'd16, 5'd1);
    dut.insn_memory.mem[5] = enc_i(12'd3, 5'd1, 3'd0, 5'd2, 7'h67);
    reset = 1'b1;
    step(); check("pre_jal_pc", dut.pc, 32'd4);
    step(); check("jal_pc", dut.pc, 32'd20); check("jal_link", dut.register_file.regFile[1], 32'd8);
    step(); check("jalr_pc", dut.pc, 32'd10); check("jalr_link", dut.register_file.regFile[2], 32'd24);
    step(); check("unaligned_pc_step", dut.pc, 32'd14);
    $display("seq jump pc=%08h", dut.pc);

    // ---------------- AUIPC at 0x10, LUI ----------------
    prep();
    dut.insn_memory.mem[4] = enc_u(20'h00001, 5'd3, 7'h17);
    dut.insn_memory.mem[5] = enc_u(20'h12345, 5'd4, 7'h37);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("auipc_0x10", dut.register_file.regFile[3], 32'h0000_1010);
    step();
    check("lui_seq", dut.register_file.regFile[4], 32'h1234_5000);
    $display("seq upper x3=%08h x4=%08h", dut.register_file.regFile[3], dut.register_file.regFile[4]);

    // ---------------- random program against reference model ----------------
    prep();
    for (int k = 0; k < 1024; k++) mb[k] = 8'd0;
    mreg[0] = 32'd0;
    dut.register_file.regFile[0] = $urandom;
    for (int k = 1; k < 32; k++) begin
      mreg[k] = $urandom;
      dut.register_file.regFile[k] = mreg[k];
    end
    for (int n = 0; n < 300; n++) begin
      op_t o;
      o.kind = $urandom_range(0, 26);
      o.rd   = 5'($urandom_range(1, 31));
      o.rs1  = 5'($urandom_range(0, 31));
      o.rs2  = 5'($urandom_range(0, 31));
      o.imm  = 12'($urandom);
      o.uimm = 20'($urandom);
      if (o.kind >= 16 && o.kind <= 18) o.imm = {(o.kind == 18) ? 7'h20 : 7'h00, 5'($urandom)};
      if (o.kind == 20 || o.kind == 21) o.imm = 12'($urandom_range(0, 15) * 4);
      if (o.kind == 22 || o.kind == 23 || o.kind == 24) o.imm = 12'($urandom_range(0, 63));
      if (o.kind == 25 || o.kind == 26) o.imm = 12'($urandom_range(0, 31) * 2);
      ops.push_back(o);
      dut.insn_memory.mem[n] = encode_op(o);
    end
    reset = 1'b1;
    foreach (ops[n]) begin
      op_t         o;
      logic [31:0] a, b, si, r;
      int          ad;
      o  = ops[n];
      a  = mreg[o.rs1];
      b  = mreg[o.rs2];
      si = {{20{o.imm[11]}}, o.imm};
      ad = int'(o.imm);
      r  = 32'd0;
      case (o.kind)
        0:  r = a + b;
        1:  r = a - b;
        2:  r = a << b[4:0];
        3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4:  r = (a < b) ? 32'd1 : 32'd0;
        5:  r = a ^ b;
        6:  r = a >> b[4:0];
        7:  r = $signed(a) >>> b[4:0];
        8:  r = a | b;
        9:  r = a & b;
        10: r = a + si;
        11: r = ($signed(a) < $signed(si)) ? 32'd1 : 32'd0;
        12: r = (a < si) ? 32'd1 : 32'd0;
        13: r = a ^ si;
        14: r = a | si;
        15: r = a & si;
        16: r = a << o.imm[4:0];
        17: r = a >> o.imm[4:0];
        18: r = $signed(a) >>> o.imm[4:0];
        19: r = {o.uimm, 12'd0};
        20: for (int i = 0; i < 4; i++) mb[ad+i] = b[8*i +: 8];
        21: r = {mb[ad+3], mb[ad+2], mb[ad+1], mb[ad]};
        22: mb[ad] = b[7:0];
        23: r = {24'd0, mb[ad]};
        24: r = {{24{mb[ad][7]}}, mb[ad]};
        25: begin mb[ad] = b[7:0]; mb[ad+1] = b[15:8]; end
        default: r = {{16{mb[ad+1][7]}}, mb[ad+1], mb[ad]};
      endcase
      step();
      if (o.kind == 20 || o.kind == 22 || o.kind == 25) begin
        int w;
        w = ad / 4;
        check($sformatf("rand%0d_store", n), dut.data_memory.mem[w],
              {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]});
      end else begin
        mreg[o.rd] = r;
        check($sformatf("rand%0d_k%0d_rd", n, o.kind), dut.register_file.regFile[o.rd], r);
      end
      check($sformatf("rand%0d_pc", n), dut.pc, 32'(4 * (n + 1)));
      $display("rand %0d kind=%0d rd=x%0d rs1=x%0d rs2=x%0d imm=%03h", n, o.kind, o.rd, o.rs1, o.rs2, o.imm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
